// File: rtl/pwm_multi.sv
// Multi-channel PWM sharing one free-running period counter; per-channel target/active speed codes.
// Active codes update only at period boundaries (jump or one-code soft ramp); pwm is registered, one cycle behind the counter.
module pwm_multi #(
  parameter int NUM_CH  = 2,
  parameter int SPEED_W = 5,
  parameter int CNT_W   = 19,
  parameter int STEP    = 15625,
  parameter int RAMP_EN = 1
) (
  input  logic                        CLK100MHZ,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           speed_vld,
  input  logic [NUM_CH*SPEED_W-1:0]   speed,
  output logic [NUM_CH-1:0]           pwm,
  output logic                        period_tick,
  output logic [NUM_CH-1:0]           busy
);

  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [SPEED_W-1:0] CODE_MAX = '1;
  localparam logic [CNT_W:0]     FULL_W   = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0]     STEP_W   = (CNT_W+1)'(STEP);

  generate
    if ((STEP * (2**SPEED_W - 2) >= 2**CNT_W) || (NUM_CH < 1)) begin : g_param_check
      $error("pwm_multi: STEP*(2^SPEED_W-2) must be below 2^CNT_W and NUM_CH must be >= 1");
    end
  endgenerate

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [NUM_CH-1:0]  pwm_q, pwm_d;
  logic [SPEED_W-1:0] tgt_q [NUM_CH];
  logic [SPEED_W-1:0] tgt_d [NUM_CH];
  logic [SPEED_W-1:0] act_q [NUM_CH];
  logic [SPEED_W-1:0] act_d [NUM_CH];
  logic [CNT_W:0]     width [NUM_CH];
  logic               boundary;

  always_comb begin
    boundary = enable && (cnt_q == CNT_MAX);
    cnt_d    = enable ? cnt_q + CNT_W'(1) : '0;
    tick_d   = boundary;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_d[i] = speed_vld[i] ? speed[i*SPEED_W +: SPEED_W] : tgt_q[i];
      // Boundary step reads tgt_q, so a strobe on the boundary edge waits one period.
      act_d[i] = act_q[i];
      if (boundary) begin
        if (RAMP_EN == 0)             act_d[i] = tgt_q[i];
        else if (act_q[i] < tgt_q[i]) act_d[i] = act_q[i] + SPEED_W'(1);
        else if (act_q[i] > tgt_q[i]) act_d[i] = act_q[i] - SPEED_W'(1);
      end
      // Max code maps to 2^CNT_W so the compare below is always true.
      if (act_q[i] == CODE_MAX) width[i] = FULL_W;
      else                      width[i] = (CNT_W+1)'(act_q[i]) * STEP_W;
      pwm_d[i] = enable && ({1'b0, cnt_q} < width[i]);
      busy[i]  = (act_q[i] != tgt_q[i]);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= '0;
        act_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      pwm_q  <= pwm_d;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= tgt_d[i];
        act_q[i] <= act_d[i];
      end
    end
  end

  assign pwm         = pwm_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a jump instance and a ramp instance share stimulus; a period-level model checks every cycle.
module tb_pwm_multi;

  localparam int SPEED_W = 5;
  localparam int CNT_W   = 8;
  localparam int STEP    = 8;
  localparam int PERIOD  = 256;
  localparam int MAXC    = 31;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] speed_vld;
  logic [9:0] speed;
  logic [1:0] pwm_j, pwm_r, busy_j, busy_r;
  logic       tick_j, tick_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_multi #(.NUM_CH(2), .SPEED_W(SPEED_W), .CNT_W(CNT_W), .STEP(STEP), .RAMP_EN(0)) u_jump (
    .CLK100MHZ(clk), .reset_n(rst_n), .enable(enable), .speed_vld(speed_vld), .speed(speed),
    .pwm(pwm_j), .period_tick(tick_j), .busy(busy_j));

  pwm_multi #(.NUM_CH(2), .SPEED_W(SPEED_W), .CNT_W(CNT_W), .STEP(STEP), .RAMP_EN(1)) u_ramp (
    .CLK100MHZ(clk), .reset_n(rst_n), .enable(enable), .speed_vld(speed_vld), .speed(speed),
    .pwm(pwm_r), .period_tick(tick_r), .busy(busy_r));

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: index 0 = jump instance, 1 = ramp instance.
  int m_cnt = 0;
  int m_tgt [2][2];
  int m_act [2][2];
  bit m_pwm [2][2];
  bit m_tick = 1'b0;
  bit m_bnd;

  function automatic int wid(input int code);
    if (code == MAXC) return PERIOD;
    return code * STEP;
  endfunction

  initial begin
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        m_tgt[r][c] = 0; m_act[r][c] = 0; m_pwm[r][c] = 1'b0;
      end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_tick = 1'b0;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          m_tgt[r][c] = 0; m_act[r][c] = 0; m_pwm[r][c] = 1'b0;
        end
    end else begin
      m_bnd  = enable && (m_cnt == PERIOD - 1);
      m_tick = m_bnd;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          m_pwm[r][c] = enable && (m_cnt < wid(m_act[r][c]));
          if (m_bnd) begin
            if (r == 0)                          m_act[r][c] = m_tgt[r][c];
            else if (m_act[r][c] < m_tgt[r][c]) m_act[r][c] = m_act[r][c] + 1;
            else if (m_act[r][c] > m_tgt[r][c]) m_act[r][c] = m_act[r][c] - 1;
          end
        end
      for (int c = 0; c < 2; c++)
        if (speed_vld[c])
          for (int r = 0; r < 2; r++) m_tgt[r][c] = int'(speed[c*SPEED_W +: SPEED_W]);
      m_cnt = enable ? (m_cnt + 1) % PERIOD : 0;
    end
  end

  always @(negedge clk) begin
    check("tick_jump", tick_j, m_tick);
    check("tick_ramp", tick_r, m_tick);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("pwm_jump[%0d]", c), pwm_j[c], m_pwm[0][c]);
      check($sformatf("pwm_ramp[%0d]", c), pwm_r[c], m_pwm[1][c]);
      check($sformatf("busy_jump[%0d]", c), busy_j[c], int'(m_act[0][c] != m_tgt[0][c]));
      check($sformatf("busy_ramp[%0d]", c), busy_r[c], int'(m_act[1][c] != m_tgt[1][c]));
    end
  end

  // Waits for a tick, then counts high cycles over the following period; gap = cycles to next tick.
  task automatic measure(output int hj0, output int hj1, output int hr0, output int hr1, output int gap);
    int budget = 0;
    hj0 = 0; hj1 = 0; hr0 = 0; hr1 = 0; gap = 0;
    while (tick_j !== 1'b1 && budget < 600) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 600) check("tick_wait_timeout", 0, 1);
    for (int k = 1; k <= PERIOD; k++) begin
      @(negedge clk);
      hj0 += int'(pwm_j[0]); hj1 += int'(pwm_j[1]);
      hr0 += int'(pwm_r[0]); hr1 += int'(pwm_r[1]);
      if (tick_j === 1'b1 && gap == 0) gap = k;
    end
  endtask

  task automatic load(input logic [1:0] vld, input int c0, input int c1);
    @(negedge clk);
    speed     = {5'(c1), 5'(c0)};
    speed_vld = vld;
    @(negedge clk);
    speed_vld = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hj0, hj1, hr0, hr1, gap, acc0, acc1;
    rst_n = 1'b1; enable = 1'b0; speed_vld = 2'b00; speed = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_pwm_jump", pwm_j, 0);
    check("reset_tick", tick_j, 0);
    check("reset_busy_ramp", busy_r, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    enable = 1'b1;

    // Jump vs ramp: ch0 -> 4, ch1 -> 3.
    load(2'b11, 4, 3);
    measure(hj0, hj1, hr0, hr1, gap);
    check("p1_jump_ch0_high", hj0, 32);
    check("p1_jump_ch1_high", hj1, 24);
    check("p1_ramp_ch0_high", hr0, 8);
    check("p1_ramp_ch1_high", hr1, 8);
    check("p1_tick_gap", gap, 256);
    check("p1_ramp_busy1", busy_r[1], 1);
    measure(hj0, hj1, hr0, hr1, gap);
    check("p2_jump_ch0_high", hj0, 32);
    check("p2_ramp_ch0_high", hr0, 16);
    check("p2_ramp_ch1_high", hr1, 16);
    check("p2_tick_gap", gap, 256);
    check("b3_ramp_busy1_dropped", busy_r[1], 0);
    check("b3_ramp_busy0_still", busy_r[0], 1);
    measure(hj0, hj1, hr0, hr1, gap);
    check("p3_ramp_ch0_high", hr0, 24);
    check("p3_ramp_ch1_high", hr1, 24);
    measure(hj0, hj1, hr0, hr1, gap);
    check("p4_ramp_ch0_high", hr0, 32);
    check("p4_ramp_ch1_high", hr1, 24);

    // Extreme codes across three wraps.
    load(2'b11, 0, MAXC);
    measure(hj0, hj1, hr0, hr1, gap);
    acc0 = 0; acc1 = 0;
    for (int p = 0; p < 3; p++) begin
      measure(hj0, hj1, hr0, hr1, gap);
      acc0 += hj0; acc1 += hj1;
    end
    check("code0_const_low", acc0, 0);
    check("code31_const_high", acc1, 768);

    // Strobe on the boundary edge.
    load(2'b01, 2, MAXC);
    measure(hj0, hj1, hr0, hr1, gap);
    check("pre_bnd_code2_high", hj0, 16);
    repeat (255) @(negedge clk);
    speed     = {5'(MAXC), 5'd10};
    speed_vld = 2'b01;
    @(negedge clk);
    speed_vld = 2'b00;
    check("bnd_tick_seen", tick_j, 1);
    measure(hj0, hj1, hr0, hr1, gap);
    check("n1_uses_old_target", hj0, 16);
    measure(hj0, hj1, hr0, hr1, gap);
    check("n2_uses_new_target", hj0, 80);

    // Enable drop mid-period.
    repeat (100) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_pwm_jump", pwm_j, 0);
    repeat (20) @(negedge clk);
    enable = 1'b1;
    gap = 0;
    for (int k = 1; k <= 600 && gap == 0; k++) begin
      @(negedge clk);
      if (tick_j === 1'b1) gap = k;
    end
    check("reenable_tick_gap", gap, 256);
    measure(hj0, hj1, hr0, hr1, gap);
    check("reenable_ch0_preserved", hj0, 80);
    check("reenable_ch1_preserved", hj1, 256);

    // Asynchronous reset mid-ramp.
    load(2'b11, 20, 5);
    repeat (300) @(negedge clk);
    check("pre_reset_ramp_busy0", busy_r[0], 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_pwm_jump", pwm_j, 0);
    check("async_rst_pwm_ramp", pwm_r, 0);
    check("async_rst_tick", int'(tick_j | tick_r), 0);
    check("async_rst_busy_ramp", busy_r, 0);
    check("async_rst_busy_jump", busy_j, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy_ramp", busy_r, 0);
    check("post_rst_pwm_ramp", pwm_r, 0);
    check("post_rst_pwm_jump", pwm_j, 0);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      speed     = 10'($urandom);
      speed_vld = ($urandom_range(0, 99) < 3) ? 2'($urandom) : 2'b00;
      if (enable && $urandom_range(0, 999) < 1) enable = 1'b0;
      else if (!enable && $urandom_range(0, 19) < 1) enable = 1'b1;
    end
    @(negedge clk);
    speed_vld = 2'b00;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
